dmem_store_buffer: RTL and testbench

Posted-write store buffer between the pipelined core's memory stage and the data memory write bus. It accepts stores from the core in the M stage, holds up to DEPTH of them in a FIFO, and drains them in order over a valid/ready write channel. Loads issued in the M stage take their data from the youngest matching buffered store, or from the memory's combinational read port when no store matches, so the core always sees program-order memory contents.

---
 rtl/dmem_store_buffer.sv | 94 +++++++++
 tb/tb_dmem_store_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the M stage and the data memory.
// Buffers stores in order and forwards the youngest match to loads.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic        sb_full,
  output logic        sb_empty,
  output logic        sb_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [AW-1:0] idx;
  logic          unused_lsb;

  assign unused_lsb  = ^aluresultM[1:0];

  assign sb_empty    = (count == '0);
  assign sb_full     = (count == CW'(DEPTH));
  assign sb_overflow = ovf;
  assign wr_valid    = !sb_empty;
  assign pop         = wr_valid && wr_ready;
  assign push        = mem_write && (!sb_full || pop);

  assign wr_addr     = wr_valid ? {addr_q[head], 2'b00} : '0;
  assign wr_data     = wr_valid ? data_q[head] : '0;
  assign mem_rd_addr = {aluresultM[31:2], 2'b00};
  assign readdataM   = fwd_hit ? fwd_data : mem_rd_data;

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (mem_write && !push) ovf <= 1'b1;
    end
  end

  // Entry storage; contents are don't-care until occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= aluresultM[31:2];
      data_q[tail] <= writedataM;
    end
  end

  // Scan head to tail so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) &&
          (addr_q[idx] == aluresultM[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed plan plus random
// traffic against a queue-based reference model.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] aluresultM = '0;
  logic [31:0] writedataM = '0;
  logic [31:0] readdataM;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready = 1'b0;
  logic        sb_full;
  logic        sb_empty;
  logic        sb_overflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf = 1'b0;
  logic [31:0] mem [logic [29:0]];

  logic [31:0] s_rd;
  logic [31:0] s_wa;
  logic [31:0] s_wd;
  logic        s_valid;
  logic        s_full;
  logic        s_empty;
  logic        s_ovf;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .mem_write(mem_write),
    .aluresultM(aluresultM),
    .writedataM(writedataM),
    .readdataM(readdataM),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .sb_full(sb_full),
    .sb_empty(sb_empty),
    .sb_overflow(sb_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a,
                                           input logic [31:0] rd);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a[31:2]) return q[i].d;
    return rd;
  endfunction

  task automatic model_clear();
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic step(input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy,
                      input logic [31:0] rd);
    logic pop;
    logic push;
    ent_t e;
    @(negedge clk);
    mem_write   = mw;
    aluresultM  = a;
    writedataM  = d;
    wr_ready    = rdy;
    mem_rd_data = rd;
    #1;
    s_rd    = readdataM;
    s_wa    = wr_addr;
    s_wd    = wr_data;
    s_valid = wr_valid;
    s_full  = sb_full;
    s_empty = sb_empty;
    s_ovf   = sb_overflow;
    check("wr_valid", 32'(wr_valid), 32'(q.size() > 0));
    check("wr_addr", wr_addr,
          q.size() > 0 ? {q[0].a, 2'b00} : 32'h0);
    check("wr_data", wr_data, q.size() > 0 ? q[0].d : 32'h0);
    check("readdataM", readdataM, model_rd(a, rd));
    check("mem_rd_addr", mem_rd_addr, {a[31:2], 2'b00});
    check("sb_full", 32'(sb_full), 32'(q.size() == DEPTH));
    check("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    check("sb_overflow", 32'(sb_overflow), 32'(m_ovf));
    pop  = (q.size() > 0) && rdy;
    push = mw && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    if (pop) begin
      mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (push) begin
      e.a = a[31:2];
      e.d = d;
      q.push_back(e);
    end
    if (mw && !push) m_ovf = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_write = 1'b0;
    wr_ready = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] ra;
    logic        rmw;
    logic        rrdy;

    // Reset state
    #2;
    check("rst_valid", 32'(wr_valid), 32'h0);
    check("rst_empty", 32'(sb_empty), 32'h1);
    check("rst_full", 32'(sb_full), 32'h0);
    check("rst_waddr", wr_addr, 32'h0);
    do_reset();

    // Three stores held, then drained in order
    step(1, 32'h100, 32'hA1, 0, 0);
    step(1, 32'h104, 32'hA2, 0, 0);
    step(1, 32'h108, 32'hA3, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    check("t1_valid", 32'(s_valid), 32'h1);
    check("t1_addr", s_wa, 32'h100);
    check("t1_data", s_wd, 32'hA1);
    step(0, 32'h0, 0, 0, 0);
    check("t1_hold_addr", s_wa, 32'h100);
    check("t1_hold_data", s_wd, 32'hA1);
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 0, 1, 0);
      check("t1_drain_addr", s_wa, 32'h100 + 32'(4 * i));
      check("t1_drain_data", s_wd, 32'hA1 + 32'(i));
    end
    step(0, 32'h0, 0, 0, 0);
    check("t1_empty", 32'(s_empty), 32'h1);

    // Youngest matching store wins
    step(1, 32'h200, 32'h11, 0, mem_val(32'h200));
    step(1, 32'h200, 32'h22, 0, mem_val(32'h200));
    step(0, 32'h203, 0, 0, 32'hDEAD);
    check("t2_fwd", s_rd, 32'h22);
    step(0, 32'h204, 0, 0, 32'hDEAD);
    check("t2_miss", s_rd, 32'hDEAD);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 1, 0);

    // Overflow drops the fifth store
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 0, 0);
    step(0, 32'h0, 0, 0, 0);
    check("t3_full", 32'(s_full), 32'h1);
    step(1, 32'h310, 32'hBF, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    check("t3_ovf", 32'(s_ovf), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 0, 1, 0);
      check("t3_drain", s_wd, 32'hB0 + 32'(i));
    end
    step(0, 32'h0, 0, 0, 0);
    check("t3_empty", 32'(s_empty), 32'h1);
    check("t3_ovf_sticky", 32'(s_ovf), 32'h1);

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, 32'h400 + 32'(4 * i), 32'hC0 + 32'(i), 0, 0);
    step(1, 32'h410, 32'hC4, 1, 0);
    step(0, 32'h0, 0, 0, 0);
    check("t4_full", 32'(s_full), 32'h1);
    check("t4_no_ovf", 32'(s_ovf), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 0, 1, 0);
      check("t4_drain", s_wd, 32'hC1 + 32'(i));
    end

    // Load of head in its pop cycle, then from memory
    step(1, 32'h500, 32'hD5, 0, 0);
    step(0, 32'h500, 0, 1, 32'h1234);
    check("t5_pop_fwd", s_rd, 32'hD5);
    step(0, 32'h500, 0, 0, 32'h5555);
    check("t5_after_pop", s_rd, 32'h5555);

    // Asynchronous reset mid-drain
    step(1, 32'h600, 32'hE0, 0, 0);
    step(1, 32'h604, 32'hE1, 0, 0);
    @(negedge clk);
    mem_write = 1'b0;
    wr_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid", 32'(wr_valid), 32'h0);
    check("t6_empty", 32'(sb_empty), 32'h1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(0, 32'h600, 0, 0, 32'h7777);
    check("t6_load", s_rd, 32'h7777);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ra   = 32'h700 + 32'(4 * $urandom_range(0, 7))
             + 32'($urandom_range(0, 3));
      rmw  = ($urandom_range(0, 99) < 55);
      rrdy = ($urandom_range(0, 99) < 45);
      step(rmw, ra, $urandom, rrdy, mem_val(ra));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
